stereo_smpl_queue: RTL

Stereo circular sample queue that sits directly upstream of a band FIR stage. It stores the most recent DEPTH left/right audio samples. Once the queue is full, every new sample triggers a burst readout of all DEPTH stored samples, oldest to newest, one per clock. The burst is framed by `sequencing`, which is exactly the input the FIR multiply-accumulate stage keys on.

---
 rtl/stereo_smpl_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/stereo_smpl_queue.sv
// -----------------------------------------------------------------------------
// stereo_smpl_queue
//
// Stereo circular sample queue feeding a band FIR stage. It holds the most
// recent DEPTH left/right sample pairs. Once full, every accepted sample
// triggers a burst readout of all DEPTH stored pairs, oldest to newest, one
// per clock, framed by `sequencing`.
//
// Parameters:
//   DEPTH   number of stereo samples held and burst length (>= 2)
//   DATA_W  sample width, signed two's complement
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   wrt_smpl    single-cycle strobe: new pair on lft_smpl/rght_smpl
//   lft_smpl    left input sample
//   rght_smpl   right input sample
//   sequencing  high for exactly DEPTH cycles while a burst is presented
//   lft_out     left burst sample (registered, 0 outside a burst)
//   rght_out    right burst sample (registered, 0 outside a burst)
//   drop_cnt    saturating count of strobes dropped during a burst; present
//               only when the macro SMPL_QUEUE_DROP_CNT_EN is defined
// -----------------------------------------------------------------------------
module stereo_smpl_queue #(
  parameter int DEPTH  = 1021,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_smpl,
  input  logic [DATA_W-1:0] lft_smpl,
  input  logic [DATA_W-1:0] rght_smpl,
  output logic              sequencing,
  output logic [DATA_W-1:0] lft_out,
  output logic [DATA_W-1:0] rght_out
`ifdef SMPL_QUEUE_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(DEPTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  logic [DATA_W-1:0] lft_mem  [DEPTH];
  logic [DATA_W-1:0] rght_mem [DEPTH];

  logic [0:0]        state;
  logic [PTR_W-1:0]  new_ptr;
  logic [PTR_W-1:0]  old_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fill_cnt;
  logic [PTR_W-1:0]  burst_cnt;

  // Read-data stage: rd_valid marks that lft_rd/rght_rd hold a burst sample.
  logic              rd_valid;
  logic [DATA_W-1:0] lft_rd;
  logic [DATA_W-1:0] rght_rd;

  logic              wr_en;
  logic              rd_en;
  logic [PTR_W-1:0]  old_ptr_nxt;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Reset wins over a coincident strobe, so the sample is never stored.
  assign wr_en = (state == IDLE) && wrt_smpl && !rst;
  assign rd_en = (state == READ);

  // Once the queue is full the oldest slot is overwritten, so old_ptr moves
  // with the write. The burst must start from this post-update value.
  assign old_ptr_nxt = (fill_cnt == FULL) ? wrap_inc(old_ptr) : old_ptr;

  // NOTE: all registered state uses non-blocking (<=) so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      new_ptr   <= '0;
      old_ptr   <= '0;
      rd_ptr    <= '0;
      fill_cnt  <= '0;
      burst_cnt <= '0;
      rd_valid  <= 1'b0;
`ifdef SMPL_QUEUE_DROP_CNT_EN
      drop_cnt  <= '0;
`endif
    end else begin
      rd_valid <= rd_en;
      if (state == IDLE) begin
        if (wrt_smpl) begin
          new_ptr <= wrap_inc(new_ptr);
          old_ptr <= old_ptr_nxt;
          if (fill_cnt != FULL) begin
            fill_cnt <= fill_cnt + 1'b1;
          end
          // Post-write fill reaches DEPTH exactly when pre-write fill is
          // DEPTH-1 or already DEPTH.
          if (fill_cnt >= FULL_M1) begin
            state     <= READ;
            rd_ptr    <= old_ptr_nxt;
            burst_cnt <= '0;
          end
        end
      end else begin
        rd_ptr <= wrap_inc(rd_ptr);
        if (burst_cnt == LAST_SLOT) begin
          state     <= IDLE;
          burst_cnt <= '0;
        end else begin
          burst_cnt <= burst_cnt + 1'b1;
        end
`ifdef SMPL_QUEUE_DROP_CNT_EN
        if (wrt_smpl && (drop_cnt != 8'hFF)) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
`endif
      end
    end
  end

  // NOTE: the sample arrays and read registers are deliberately not reset;
  // no slot is read before it is written, and rd_valid gates the read data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lft_mem[new_ptr]  <= lft_smpl;
      rght_mem[new_ptr] <= rght_smpl;
    end
    if (rd_en) begin
      lft_rd  <= lft_mem[rd_ptr];
      rght_rd <= rght_mem[rd_ptr];
    end
  end

  // Framing and data share one register stage so they can never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      sequencing <= 1'b0;
      lft_out    <= '0;
      rght_out   <= '0;
    end else begin
      sequencing <= rd_valid;
      lft_out    <= rd_valid ? lft_rd  : '0;
      rght_out   <= rd_valid ? rght_rd : '0;
    end
  end

endmodule
